backend_frontend_port: RTL and testbench
========================================

Name: backend_frontend_port

Overview:
- Backend-side endpoint of the Global_Controller to backend-controller (bcN) link; one instance per backend channel.
- Command path: accepts frontend command and write data under a ready/valid handshake and buffers them in a command FIFO. The local DRAM scheduler drains that FIFO.
- Return path: issues ren credits to the global controller, captures returned data, and buffers it for local consumption.

Parameters:
- WORD_W, `GLOBAL_CONTROLLER_WORD_SIZE, width of write and returned data words.
- CMD_W, $bits(frontend_command_t), width of the command bus.
- CMD_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- RET_DEPTH, 4, returned-data FIFO entries; power of 2, ≥2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frontend_command_valid  in  1  global controller offers a command.
- i_frontend_command  in  CMD_W  command (frontend_command_t), treated as opaque payload.
- i_frontend_write_data  in  WORD_W  write data accompanying the command.
- o_backend_controller_ready  out  1  port can accept a command this cycle.
- o_sched_cmd_valid  out  1  FIFO head valid.
- o_sched_cmd  out  CMD_W  FIFO head command.
- o_sched_wdata  out  WORD_W  FIFO head write data.
- i_sched_cmd_ready  in  1  scheduler pops the head.
- o_backend_controller_ren  out  1  one-word return credit to the global controller.
- i_returned_data_valid  in  1  returned word present.
- i_returned_data  in  WORD_W  returned word.
- o_ret_valid  out  1  return FIFO head valid.
- o_ret_data  out  WORD_W  return FIFO head.
- i_ret_ready  in  1  consumer pops the return head.
- o_protocol_err  out  1  sticky: data returned with no outstanding credit.

Behaviour:
- Reset (async assert, sync-released by flop behaviour): FIFOs empty, pointers and counts 0, outstanding 0.
- Output values during reset: o_backend_controller_ready=0, o_sched_cmd_valid=0, o_ret_valid=0, o_backend_controller_ren=0, o_protocol_err=0; data outputs 0.
- Reset mid-transfer discards all buffered commands, data and credits.
- Command FIFO:
  - o_backend_controller_ready is registered, =1 iff cmd_count<CMD_DEPTH; it is 1 from the first clock edge after reset release.
  - Push on valid&&ready; command and write data are captured in the same entry.
  - Pop on o_sched_cmd_valid&&i_sched_cmd_ready.
  - o_sched_cmd_valid = (cmd_count!=0).
  - Head outputs come directly from the storage read at rd_ptr, with no extra latency. A pushed entry is visible at the head on the cycle after the push edge.
  - Push and pop in the same cycle: count unchanged; allowed when full (pop frees the slot) and when empty (no bypass, valid rises next cycle).
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
  - Valid while ready=0 is ignored; the global controller holds its command.
- Return path credit rule: o_backend_controller_ren (registered) =1 iff ret_count+outstanding+issued_this_cycle < RET_DEPTH. The FIFO can never overflow regardless of return latency (≥1 cycle).
- outstanding counter:
  - +1 each cycle ren=1, −1 each cycle i_returned_data_valid=1; both in one cycle leaves it unchanged.
  - Width log2(RET_DEPTH)+1.
- Returned word: pushed into the return FIFO when i_returned_data_valid=1 and outstanding!=0.
  - If outstanding==0: word dropped, o_protocol_err set and held until reset, counters unchanged.
- Return FIFO pop on o_ret_valid&&i_ret_ready. Same-cycle push/pop rules as the command FIFO.
- Ordering: strict FIFO on both paths; no reordering, no read/write decode.

Test Plan:
- Reset then 4 back-to-back commands (data 0x11..0x44) with i_sched_cmd_ready=0:
  - ready drops to 0 the cycle after the 4th acceptance.
  - A 5th valid is held and not accepted.
  - Head = 0x11.
- Full FIFO, then i_sched_cmd_ready=1 while a command is offered:
  - Pops 0x11, 0x22, 0x33, 0x44, 0x55 in order.
  - Count stays 4 during simultaneous push/pop cycles.
- i_ret_ready=0, global controller returns each word 3 cycles after ren:
  - ren asserted for exactly 4 cycles total.
  - 4 words buffered, no overflow, ren then stays 0.
- Drain one return word:
  - ren reasserts for one cycle.
  - Outstanding 1, then 0 after the returned word arrives.
- i_returned_data_valid pulse with no prior ren:
  - o_protocol_err=1 next cycle and stays 1.
  - o_ret_valid stays 0.
- Assert i_rst_n=0 asynchronously with 2 commands and 2 credits outstanding:
  - All outputs 0 immediately.
  - After release: ready=1, ren=1 on the first edge, FIFOs empty.

Source files
------------

// File: rtl/backend_frontend_port.sv
// ---------------------------------------------------------------------------
// backend_frontend_port
//
// Backend-side endpoint of the global-controller-to-backend-controller link.
// One instance per backend channel.
//
// Command path: frontend commands and their write data are accepted under a
// ready/valid handshake into a small FIFO. The local DRAM scheduler drains
// that FIFO from its head.
//
// Return path: one-word read credits (ren) are issued to the global
// controller only while the return FIFO is guaranteed to have room for every
// word already requested. Returned words are buffered for local consumption.
// A word arriving with no credit outstanding is dropped and flagged in a
// sticky protocol error.
//
// Ports
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_frontend_command_valid     global controller offers a command
//   i_frontend_command           opaque command payload
//   i_frontend_write_data        write data that travels with the command
//   o_backend_controller_ready   registered, command FIFO has a free slot
//   o_sched_cmd_valid            command FIFO head valid
//   o_sched_cmd, o_sched_wdata   command FIFO head
//   i_sched_cmd_ready            scheduler pops the command head
//   o_backend_controller_ren     registered one-word return credit
//   i_returned_data_valid        returned word present
//   i_returned_data              returned word
//   o_ret_valid, o_ret_data      return FIFO head
//   i_ret_ready                  consumer pops the return head
//   o_protocol_err               sticky: word returned with no credit
// ---------------------------------------------------------------------------

`ifndef GLOBAL_CONTROLLER_WORD_SIZE
`define GLOBAL_CONTROLLER_WORD_SIZE 32
`endif

module backend_frontend_port #(
  parameter int WORD_W    = `GLOBAL_CONTROLLER_WORD_SIZE,
  parameter int CMD_W     = 16,  // $bits(frontend_command_t) in the system build
  parameter int CMD_DEPTH = 4,   // power of 2, >= 2
  parameter int RET_DEPTH = 4    // power of 2, >= 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frontend_command_valid,
  input  logic [CMD_W-1:0]  i_frontend_command,
  input  logic [WORD_W-1:0] i_frontend_write_data,
  output logic              o_backend_controller_ready,
  output logic              o_sched_cmd_valid,
  output logic [CMD_W-1:0]  o_sched_cmd,
  output logic [WORD_W-1:0] o_sched_wdata,
  input  logic              i_sched_cmd_ready,
  output logic              o_backend_controller_ren,
  input  logic              i_returned_data_valid,
  input  logic [WORD_W-1:0] i_returned_data,
  output logic              o_ret_valid,
  output logic [WORD_W-1:0] o_ret_data,
  input  logic              i_ret_ready,
  output logic              o_protocol_err
);

  localparam int CAW     = $clog2(CMD_DEPTH);
  localparam int RAW     = $clog2(RET_DEPTH);
  localparam int ENTRY_W = CMD_W + WORD_W;

  localparam logic [CAW:0]   CMD_CAP = (CAW+1)'(CMD_DEPTH);
  localparam logic [CAW:0]   CMD_ONE = (CAW+1)'(1);
  localparam logic [RAW:0]   RET_ONE = (RAW+1)'(1);
  localparam logic [RAW+1:0] RET_CAP = (RAW+2)'(RET_DEPTH);

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [ENTRY_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CAW-1:0]     cmd_wr_ptr;
  logic [CAW-1:0]     cmd_rd_ptr;
  logic [CAW:0]       cmd_count;
  logic [CAW:0]       cmd_count_next;
  logic               cmd_ready_q;
  logic               cmd_valid;
  logic               cmd_push;
  logic               cmd_pop;
  logic [ENTRY_W-1:0] cmd_head;

  assign cmd_valid = (cmd_count != '0);
  assign cmd_push  = i_frontend_command_valid && cmd_ready_q;
  assign cmd_pop   = cmd_valid && i_sched_cmd_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cmd_count_next = cmd_count;
    if (cmd_push && !cmd_pop)      cmd_count_next = cmd_count + CMD_ONE;
    else if (!cmd_push && cmd_pop) cmd_count_next = cmd_count - CMD_ONE;
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy is tracked by the
  // count, and the head outputs are forced to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {i_frontend_command, i_frontend_write_data};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_wr_ptr  <= '0;
      cmd_rd_ptr  <= '0;
      cmd_count   <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      cmd_count   <= cmd_count_next;
      // Registered from the next count, so it equals (count < depth) on
      // every cycle and rises on the first edge after reset release.
      cmd_ready_q <= (cmd_count_next < CMD_CAP);
    end
  end

  assign cmd_head                   = cmd_mem[cmd_rd_ptr];
  assign o_backend_controller_ready = cmd_ready_q;
  assign o_sched_cmd_valid          = cmd_valid;
  assign o_sched_cmd                = cmd_valid ? cmd_head[ENTRY_W-1:WORD_W] : '0;
  assign o_sched_wdata              = cmd_valid ? cmd_head[WORD_W-1:0] : '0;

  // -------------------------------------------------------------------------
  // Return path: credits, outstanding tracking and return FIFO
  // -------------------------------------------------------------------------
  logic [WORD_W-1:0] ret_mem [RET_DEPTH];
  logic [RAW-1:0]    ret_wr_ptr;
  logic [RAW-1:0]    ret_rd_ptr;
  logic [RAW:0]      ret_count;
  logic [RAW:0]      ret_count_next;
  logic [RAW:0]      outstanding;
  logic [RAW:0]      outstanding_next;
  logic [RAW+1:0]    credit_sum;
  logic              ren_q;
  logic              err_q;
  logic              ret_valid;
  logic              ret_push;
  logic              ret_pop;
  logic              ret_orphan;

  assign ret_valid  = (ret_count != '0);
  // A word is only accepted against a credit; an orphan word is dropped.
  assign ret_push   = i_returned_data_valid && (outstanding != '0);
  assign ret_orphan = i_returned_data_valid && (outstanding == '0);
  assign ret_pop    = ret_valid && i_ret_ready;

  always_comb begin
    ret_count_next = ret_count;
    if (ret_push && !ret_pop)      ret_count_next = ret_count + RET_ONE;
    else if (!ret_push && ret_pop) ret_count_next = ret_count - RET_ONE;

    outstanding_next = outstanding;
    if (ren_q && !ret_push)      outstanding_next = outstanding + RET_ONE;
    else if (!ren_q && ret_push) outstanding_next = outstanding - RET_ONE;

    // Slots already used plus slots already promised, including the credit
    // being issued this cycle. Keeping this below the depth means the FIFO
    // cannot overflow whatever the return latency is.
    credit_sum = {1'b0, ret_count_next} + {1'b0, outstanding_next};
  end

  always_ff @(posedge i_clk) begin
    if (ret_push) ret_mem[ret_wr_ptr] <= i_returned_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ret_wr_ptr  <= '0;
      ret_rd_ptr  <= '0;
      ret_count   <= '0;
      outstanding <= '0;
      ren_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (ret_push) ret_wr_ptr <= ret_wr_ptr + RAW'(1);
      if (ret_pop)  ret_rd_ptr <= ret_rd_ptr + RAW'(1);
      ret_count   <= ret_count_next;
      outstanding <= outstanding_next;
      ren_q       <= (credit_sum < RET_CAP);
      if (ret_orphan) err_q <= 1'b1;
    end
  end

  assign o_backend_controller_ren = ren_q;
  assign o_ret_valid              = ret_valid;
  assign o_ret_data               = ret_valid ? ret_mem[ret_rd_ptr] : '0;
  assign o_protocol_err           = err_q;

endmodule

// File: tb/tb_backend_frontend_port.sv
// ---------------------------------------------------------------------------
// tb_backend_frontend_port
//
// Self-checking bench for backend_frontend_port. A queue-based reference
// model steps on every rising edge from the sampled inputs; a small global
// controller model answers each ren credit with a random word three cycles
// later. Directed scenarios are followed by a randomized traffic run.
// ---------------------------------------------------------------------------

module tb_backend_frontend_port;

  localparam int WORD_W    = 32;
  localparam int CMD_W     = 16;
  localparam int CMD_DEPTH = 4;
  localparam int RET_DEPTH = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_frontend_command_valid = 1'b0;
  logic [CMD_W-1:0]  i_frontend_command = '0;
  logic [WORD_W-1:0] i_frontend_write_data = '0;
  logic              i_sched_cmd_ready = 1'b0;
  logic              i_returned_data_valid = 1'b0;
  logic [WORD_W-1:0] i_returned_data = '0;
  logic              i_ret_ready = 1'b0;

  logic              o_backend_controller_ready;
  logic              o_sched_cmd_valid;
  logic [CMD_W-1:0]  o_sched_cmd;
  logic [WORD_W-1:0] o_sched_wdata;
  logic              o_backend_controller_ren;
  logic              o_ret_valid;
  logic [WORD_W-1:0] o_ret_data;
  logic              o_protocol_err;

  always #5 i_clk = ~i_clk;

  backend_frontend_port #(
    .WORD_W   (WORD_W),
    .CMD_W    (CMD_W),
    .CMD_DEPTH(CMD_DEPTH),
    .RET_DEPTH(RET_DEPTH)
  ) dut (
    .i_clk                     (i_clk),
    .i_rst_n                   (i_rst_n),
    .i_frontend_command_valid  (i_frontend_command_valid),
    .i_frontend_command        (i_frontend_command),
    .i_frontend_write_data     (i_frontend_write_data),
    .o_backend_controller_ready(o_backend_controller_ready),
    .o_sched_cmd_valid         (o_sched_cmd_valid),
    .o_sched_cmd               (o_sched_cmd),
    .o_sched_wdata             (o_sched_wdata),
    .i_sched_cmd_ready         (i_sched_cmd_ready),
    .o_backend_controller_ren  (o_backend_controller_ren),
    .i_returned_data_valid     (i_returned_data_valid),
    .i_returned_data           (i_returned_data),
    .o_ret_valid               (o_ret_valid),
    .o_ret_data                (o_ret_data),
    .i_ret_ready               (i_ret_ready),
    .o_protocol_err            (o_protocol_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [CMD_W-1:0]  m_cmd_q[$];
  logic [WORD_W-1:0] m_wd_q[$];
  logic [WORD_W-1:0] m_ret_q[$];
  int                m_out   = 0;
  bit                m_ready = 1'b0;
  bit                m_ren   = 1'b0;
  bit                m_err   = 1'b0;

  task automatic model_reset();
    m_cmd_q.delete();
    m_wd_q.delete();
    m_ret_q.delete();
    m_out   = 0;
    m_ready = 1'b0;
    m_ren   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    bit take_cmd, give_cmd, take_ret, give_ret;
    if (!i_rst_n) return;
    take_cmd = i_frontend_command_valid && m_ready;
    give_cmd = (m_cmd_q.size() != 0) && i_sched_cmd_ready;
    take_ret = i_returned_data_valid && (m_out > 0);
    give_ret = (m_ret_q.size() != 0) && i_ret_ready;
    if (i_returned_data_valid && m_out == 0) m_err = 1'b1;
    if (give_cmd) begin
      void'(m_cmd_q.pop_front());
      void'(m_wd_q.pop_front());
    end
    if (take_cmd) begin
      m_cmd_q.push_back(i_frontend_command);
      m_wd_q.push_back(i_frontend_write_data);
    end
    if (give_ret) void'(m_ret_q.pop_front());
    if (take_ret) m_ret_q.push_back(i_returned_data);
    m_out   = m_out + (m_ren ? 1 : 0) - (take_ret ? 1 : 0);
    m_ready = (m_cmd_q.size() < CMD_DEPTH);
    m_ren   = ((m_ret_q.size() + m_out) < RET_DEPTH);
  endtask

  // ---------------- global controller return model ----------------
  bit                gc_en      = 1'b0;
  logic [2:0]        gc_pipe    = '0;
  logic [WORD_W-1:0] gc_sent[$];
  int                ren_cycles = 0;

  task automatic gc_step();
    logic [WORD_W-1:0] w;
    if (!gc_en) return;
    if (o_backend_controller_ren) ren_cycles++;
    gc_pipe = {gc_pipe[1:0], o_backend_controller_ren};
    if (gc_pipe[2]) begin
      w = $urandom;
      gc_sent.push_back(w);
      i_returned_data_valid = 1'b1;
      i_returned_data       = w;
    end else begin
      i_returned_data_valid = 1'b0;
      i_returned_data       = '0;
    end
  endtask

  // One clock: model sees the inputs sampled at the rising edge, outputs are
  // then observed and new inputs driven at the falling edge.
  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    gc_step();
  endtask

  task automatic enter_reset();
    i_rst_n                  = 1'b0;
    gc_en                    = 1'b0;
    gc_pipe                  = '0;
    i_returned_data_valid    = 1'b0;
    i_frontend_command_valid = 1'b0;
    i_sched_cmd_ready        = 1'b0;
    i_ret_ready              = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    logic [WORD_W-1:0] mix;
    mix = o_sched_wdata | o_ret_data | WORD_W'(o_sched_cmd);
    n_checks++;
    if ({o_backend_controller_ready, o_sched_cmd_valid, o_backend_controller_ren,
         o_ret_valid, o_protocol_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl: got ready/svalid/ren/rvalid/err=%b%b%b%b%b expected 00000", tag,
               o_backend_controller_ready, o_sched_cmd_valid, o_backend_controller_ren,
               o_ret_valid, o_protocol_err);
    end
    n_checks++;
    if (mix !== '0) begin
      n_fail++;
      $display("FAIL %s_data: got cmd=%h wdata=%h rdata=%h expected all 0", tag,
               o_sched_cmd, o_sched_wdata, o_ret_data);
    end
  endtask

  // ---------------- scenarios ----------------
  logic [CMD_W-1:0]  exp_cmd[5];
  logic [WORD_W-1:0] exp_wd[5];

  task automatic test_reset();
    enter_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge i_clk);
    gc_en = 1'b1;
    gc_sent.delete();
    ren_cycles = 0;
    i_rst_n = 1'b1;
    tick();
    n_checks++;
    if (o_backend_controller_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_first_edge: got %b expected 1", o_backend_controller_ready);
    end
    n_checks++;
    if (o_backend_controller_ren !== 1'b1) begin
      n_fail++; $display("FAIL reset_ren_first_edge: got %b expected 1", o_backend_controller_ren);
    end
  endtask

  task automatic test_cmd_fill();
    i_sched_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_cmd[i] = CMD_W'($urandom);
      exp_wd[i]  = WORD_W'(8'h11 * (i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_backend_controller_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_ready_%0d: got %b expected 1", i, o_backend_controller_ready);
      end
      i_frontend_command_valid = 1'b1;
      i_frontend_command       = exp_cmd[i];
      i_frontend_write_data    = exp_wd[i];
      tick();
    end
    n_checks++;
    if (o_backend_controller_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_ready_drop: got %b expected 0", o_backend_controller_ready);
    end
    // Fifth command offered and held while the FIFO is full.
    i_frontend_command    = exp_cmd[4];
    i_frontend_write_data = exp_wd[4];
    repeat (3) begin
      tick();
      n_checks++;
      if (o_backend_controller_ready !== 1'b0 || dut.cmd_count !== 3'd4) begin
        n_fail++; $display("FAIL fill_hold: got ready=%b count=%0d expected ready=0 count=4",
                           o_backend_controller_ready, dut.cmd_count);
      end
      n_checks++;
      if (o_sched_cmd_valid !== 1'b1 || o_sched_wdata !== exp_wd[0] || o_sched_cmd !== exp_cmd[0]) begin
        n_fail++; $display("FAIL fill_head: got v=%b cmd=%h wd=%h expected v=1 cmd=%h wd=%h",
                           o_sched_cmd_valid, o_sched_cmd, o_sched_wdata, exp_cmd[0], exp_wd[0]);
      end
    end
  endtask

  task automatic test_cmd_stream();
    int  k = 0;
    bit  accepted;
    i_sched_cmd_ready = 1'b1;
    for (int c = 0; c < 20 && k < 5; c++) begin
      n_checks++;
      if (o_sched_cmd_valid !== 1'b1 || o_sched_wdata !== exp_wd[k] || o_sched_cmd !== exp_cmd[k]) begin
        n_fail++; $display("FAIL stream_pop_%0d: got v=%b cmd=%h wd=%h expected v=1 cmd=%h wd=%h", k,
                           o_sched_cmd_valid, o_sched_cmd, o_sched_wdata, exp_cmd[k], exp_wd[k]);
      end
      k++;
      accepted = i_frontend_command_valid && o_backend_controller_ready;
      tick();
      if (accepted) i_frontend_command_valid = 1'b0;
      n_checks++;
      if (dut.cmd_count !== 3'(m_cmd_q.size())) begin
        n_fail++; $display("FAIL stream_count: got %0d expected %0d", dut.cmd_count, m_cmd_q.size());
      end
    end
    n_checks++;
    if (k != 5 || o_sched_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drained: got pops=%0d valid=%b expected pops=5 valid=0",
                         k, o_sched_cmd_valid);
    end
    i_sched_cmd_ready = 1'b0;
  endtask

  task automatic test_ret_credit();
    i_ret_ready = 1'b0;
    repeat (6) begin
      tick();
      n_checks++;
      if (o_backend_controller_ren !== 1'b0) begin
        n_fail++; $display("FAIL credit_ren_idle: got %b expected 0", o_backend_controller_ren);
      end
    end
    n_checks++;
    if (ren_cycles != 4) begin
      n_fail++; $display("FAIL credit_ren_total: got %0d cycles expected 4", ren_cycles);
    end
    n_checks++;
    if (dut.ret_count !== 3'd4 || dut.outstanding !== 3'd0) begin
      n_fail++; $display("FAIL credit_occupancy: got count=%0d outstanding=%0d expected 4/0",
                         dut.ret_count, dut.outstanding);
    end
    n_checks++;
    if (gc_sent.size() < 1 || o_ret_valid !== 1'b1 || o_ret_data !== gc_sent[0]) begin
      n_fail++; $display("FAIL credit_head: got v=%b data=%h expected v=1 first returned word",
                         o_ret_valid, o_ret_data);
    end
  endtask

  task automatic test_ret_drain_one();
    i_ret_ready = 1'b1;
    tick();
    i_ret_ready = 1'b0;
    n_checks++;
    if (o_backend_controller_ren !== 1'b1) begin
      n_fail++; $display("FAIL drain_ren_rise: got %b expected 1", o_backend_controller_ren);
    end
    n_checks++;
    if (gc_sent.size() < 2 || o_ret_data !== gc_sent[1]) begin
      n_fail++; $display("FAIL drain_next_head: got %h expected second returned word", o_ret_data);
    end
    tick();
    n_checks++;
    if (o_backend_controller_ren !== 1'b0 || dut.outstanding !== 3'd1) begin
      n_fail++; $display("FAIL drain_one_credit: got ren=%b outstanding=%0d expected 0/1",
                         o_backend_controller_ren, dut.outstanding);
    end
    repeat (3) tick();
    n_checks++;
    if (dut.outstanding !== 3'd0 || dut.ret_count !== 3'd4 || ren_cycles != 5) begin
      n_fail++; $display("FAIL drain_refill: got outstanding=%0d count=%0d ren_cycles=%0d expected 0/4/5",
                         dut.outstanding, dut.ret_count, ren_cycles);
    end
  endtask

  task automatic test_reset_midflight();
    i_ret_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_frontend_command_valid = 1'b1;
      i_frontend_command       = CMD_W'($urandom);
      i_frontend_write_data    = $urandom;
      tick();
    end
    i_frontend_command_valid = 1'b0;
    i_ret_ready = 1'b0;
    tick();
    n_checks++;
    if (dut.cmd_count !== 3'd2 || dut.outstanding !== 3'd2) begin
      n_fail++; $display("FAIL midflight_setup: got cmds=%0d outstanding=%0d expected 2/2",
                         dut.cmd_count, dut.outstanding);
    end
    #2;
    enter_reset();
    #1;
    check_all_zero("midflight_reset");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    n_checks++;
    if (o_backend_controller_ready !== 1'b1 || o_backend_controller_ren !== 1'b1 ||
        o_sched_cmd_valid !== 1'b0 || o_ret_valid !== 1'b0 || o_protocol_err !== 1'b0) begin
      n_fail++; $display("FAIL midflight_release: got ready/ren/svalid/rvalid/err=%b%b%b%b%b expected 11000",
                         o_backend_controller_ready, o_backend_controller_ren, o_sched_cmd_valid,
                         o_ret_valid, o_protocol_err);
    end
  endtask

  task automatic test_protocol_err();
    enter_reset();
    @(negedge i_clk);
    i_returned_data_valid = 1'b1;
    i_returned_data       = $urandom;
    i_rst_n               = 1'b1;
    tick();
    i_returned_data_valid = 1'b0;
    repeat (5) begin
      n_checks++;
      if (o_protocol_err !== 1'b1 || o_ret_valid !== 1'b0) begin
        n_fail++; $display("FAIL protocol_err: got err=%b rvalid=%b expected err=1 rvalid=0",
                           o_protocol_err, o_ret_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    enter_reset();
    repeat (2) @(negedge i_clk);
    gc_en = 1'b1;
    gc_sent.delete();
    i_rst_n = 1'b1;
    tick();
    for (int c = 0; c < 400; c++) begin
      n_checks++;
      if (o_backend_controller_ready !== m_ready || o_backend_controller_ren !== m_ren ||
          o_protocol_err !== m_err) begin
        n_fail++; $display("FAIL rand_ctrl@%0d: got ready/ren/err=%b%b%b expected %b%b%b", c,
                           o_backend_controller_ready, o_backend_controller_ren, o_protocol_err,
                           m_ready, m_ren, m_err);
      end
      n_checks++;
      if (o_sched_cmd_valid !== (m_cmd_q.size() != 0) ||
          (m_cmd_q.size() != 0 && (o_sched_cmd !== m_cmd_q[0] || o_sched_wdata !== m_wd_q[0]))) begin
        n_fail++; $display("FAIL rand_cmd_head@%0d: got v=%b cmd=%h wd=%h expected v=%b", c,
                           o_sched_cmd_valid, o_sched_cmd, o_sched_wdata, m_cmd_q.size() != 0);
      end
      n_checks++;
      if (o_ret_valid !== (m_ret_q.size() != 0) ||
          (m_ret_q.size() != 0 && o_ret_data !== m_ret_q[0])) begin
        n_fail++; $display("FAIL rand_ret_head@%0d: got v=%b data=%h expected v=%b", c,
                           o_ret_valid, o_ret_data, m_ret_q.size() != 0);
      end
      i_frontend_command_valid = 1'($urandom_range(0, 1));
      i_frontend_command       = CMD_W'($urandom);
      i_frontend_write_data    = $urandom;
      i_sched_cmd_ready        = ($urandom_range(0, 3) != 0);
      i_ret_ready              = ($urandom_range(0, 2) != 0);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cmd_fill();
    test_cmd_stream();
    test_ret_credit();
    test_ret_drain_one();
    test_reset_midflight();
    test_protocol_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
